// File: rtl/full_st0_tap_wr_arb_pkg.sv
// Shared types and constants for the stage-0 tap memory write arbiter.
//   float_24_8   : one 32-bit tap coefficient (24-bit mantissa, 8-bit exponent)
//   TAP_W        : full tap word width (6 coefficients)
//   TAP_AW       : tap word address width
//   SUB_W        : sub-word select / value width
//   ERR_BASE_ADDR: first tap word address used by the error phases
//   upd_entry_t  : one buffered tap-update write (address + word)
//   gnt_e        : which requester owns the write port this cycle
package full_st0_tap_wr_arb_pkg;

    typedef logic [31:0] float_24_8;

    localparam int TAP_W  = 6 * $bits(float_24_8);
    localparam int TAP_AW = 5;
    localparam int SUB_W  = 32;

    localparam logic [TAP_AW-1:0] ERR_BASE_ADDR = 5'd12;

    typedef struct packed {
        logic [TAP_AW-1:0] addr;
        logic [TAP_W-1:0]  data;
    } upd_entry_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_ERR,
        GNT_UPD
    } gnt_e;

endpackage

// File: rtl/full_st0_tap_wr_arb_if.sv
// Handshake and memory-write bundle of the stage-0 tap write arbiter.
//   err_*     : error sub-write request / ready
//   upd_*     : tap-update full-word request / ready / FIFO occupancy
//   mem_*     : registered write port towards the tap memory
//   err_drop  : sticky flag, error request lost while not ready
// Modports: master = requester/memory side, slave = arbiter.
interface full_st0_tap_wr_arb_if #(
    parameter int DEPTH = 2
) ();
    import full_st0_tap_wr_arb_pkg::*;

    logic                  err_vld;
    logic [TAP_AW-1:0]     err_addr;
    logic [SUB_W-1:0]      err_sub_addr;
    logic [SUB_W-1:0]      err_sub_data;
    logic                  err_rdy;

    logic                  upd_vld;
    logic [TAP_AW-1:0]     upd_addr;
    logic [TAP_W-1:0]      upd_data;
    logic                  upd_rdy;

    logic                  mem_wr_vld;
    logic [TAP_AW-1:0]     mem_wr_address;
    logic [TAP_W-1:0]      mem_wr_data;
    logic                  mem_sub_vld;
    logic [SUB_W-1:0]      mem_sub_addr;
    logic [SUB_W-1:0]      mem_sub_data;

    logic                  err_drop;
    logic [$clog2(DEPTH):0] upd_level;

    modport master (
        output err_vld, err_addr, err_sub_addr, err_sub_data,
        input  err_rdy,
        output upd_vld, upd_addr, upd_data,
        input  upd_rdy,
        input  mem_wr_vld, mem_wr_address, mem_wr_data,
        input  mem_sub_vld, mem_sub_addr, mem_sub_data,
        input  err_drop, upd_level
    );

    modport slave (
        input  err_vld, err_addr, err_sub_addr, err_sub_data,
        output err_rdy,
        input  upd_vld, upd_addr, upd_data,
        output upd_rdy,
        output mem_wr_vld, mem_wr_address, mem_wr_data,
        output mem_sub_vld, mem_sub_addr, mem_sub_data,
        output err_drop, upd_level
    );

endinterface

// File: rtl/full_st0_tap_wr_arb_fifo.sv
// Tap-update FIFO (module full_st0_tap_wr_fifo).
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   i_push      : write i_wdata (caller guarantees not full)
//   i_pop       : drop the head entry (caller guarantees not empty)
//   o_rdata     : head entry, valid whenever o_level != 0
//   o_level     : occupancy, one bit wider than the pointers
module full_st0_tap_wr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 197
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_level;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule

// File: rtl/full_st0_tap_wr_arb.sv
// Stage-0 tap memory write-port arbiter.
// Error sub-writes (single hold register) take priority over full-word
// tap updates (buffered in full_st0_tap_wr_fifo). The granted write is
// registered onto the mem_* bus one cycle after the grant.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : full_st0_tap_wr_arb_if.slave (requests, readies, mem write, status)
// Configuration macro: FULL_ST0_TAP_ARB_FAIR_EN enables the starvation guard,
// forcing the update head after STARVE_MAX consecutive lost arbitrations.
module full_st0_tap_wr_arb
    import full_st0_tap_wr_arb_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input logic                  clk,
    input logic                  reset,
    full_st0_tap_wr_arb_if.slave bus
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic              r_hold_vld;
    logic [TAP_AW-1:0] r_hold_addr;
    logic [SUB_W-1:0]  r_hold_sub_addr;
    logic [SUB_W-1:0]  r_hold_sub_data;

    logic              r_mem_wr_vld;
    logic [TAP_AW-1:0] r_mem_wr_address;
    logic [TAP_W-1:0]  r_mem_wr_data;
    logic              r_mem_sub_vld;
    logic [SUB_W-1:0]  r_mem_sub_addr;
    logic [SUB_W-1:0]  r_mem_sub_data;
    logic              r_err_drop;

    upd_entry_t        w_push_entry;
    upd_entry_t        w_head;
    logic [LW-1:0]     w_level;
    logic              w_fifo_empty;
    logic              w_push;
    logic              w_force;
    gnt_e              w_gnt;
    logic              w_err_grant;
    logic              w_upd_grant;
    logic              w_err_rdy;
    logic              w_upd_rdy;

    assign w_push_entry = '{addr: bus.upd_addr, data: bus.upd_data};
    assign w_fifo_empty = (w_level == '0);
    // Ready is taken from the registered level only: a full FIFO stays
    // not-ready even in a cycle where its head is being popped.
    assign w_upd_rdy    = (w_level < LW'(DEPTH));
    assign w_push       = bus.upd_vld & w_upd_rdy;

    full_st0_tap_wr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(upd_entry_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_upd_grant),
        .i_wdata (w_push_entry),
        .o_rdata (w_head),
        .o_level (w_level)
    );

`ifdef FULL_ST0_TAP_ARB_FAIR_EN
    localparam int SCW = $clog2(STARVE_MAX + 1);

    logic [SCW-1:0] r_starve_cnt;

    assign w_force = (r_starve_cnt == SCW'(STARVE_MAX));

    // Counts error wins while an update waits. An error grant implies
    // w_force is low, so the counter never passes STARVE_MAX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_starve_cnt <= '0;
        else if (w_fifo_empty || w_upd_grant)
            r_starve_cnt <= '0;
        else if (w_err_grant)
            r_starve_cnt <= r_starve_cnt + 1'b1;
    end
`else
    // Strict priority: the guard can never fire, whatever STARVE_MAX says.
    assign w_force = (STARVE_MAX < 0);
`endif

    always_comb begin
        w_gnt = GNT_NONE;
        if (r_hold_vld && !w_force)
            w_gnt = GNT_ERR;
        else if (!w_fifo_empty)
            w_gnt = GNT_UPD;
    end

    assign w_err_grant = (w_gnt == GNT_ERR);
    assign w_upd_grant = (w_gnt == GNT_UPD);
    // Granting the held error frees the register for a same-cycle refill.
    assign w_err_rdy   = ~r_hold_vld | w_err_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_vld      <= 1'b0;
            r_hold_addr     <= '0;
            r_hold_sub_addr <= '0;
            r_hold_sub_data <= '0;
        end else if (bus.err_vld && w_err_rdy) begin
            r_hold_vld      <= 1'b1;
            r_hold_addr     <= bus.err_addr;
            r_hold_sub_addr <= bus.err_sub_addr;
            r_hold_sub_data <= bus.err_sub_data;
        end else if (w_err_grant) begin
            r_hold_vld      <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_wr_vld     <= 1'b0;
            r_mem_wr_address <= '0;
            r_mem_wr_data    <= '0;
            r_mem_sub_vld    <= 1'b0;
            r_mem_sub_addr   <= '0;
            r_mem_sub_data   <= '0;
            r_err_drop       <= 1'b0;
        end else begin
            r_err_drop <= r_err_drop | (bus.err_vld & ~w_err_rdy);
            case (w_gnt)
                GNT_ERR: begin
                    r_mem_wr_vld     <= 1'b1;
                    r_mem_wr_address <= r_hold_addr;
                    r_mem_wr_data    <= '0;
                    r_mem_sub_vld    <= 1'b1;
                    r_mem_sub_addr   <= r_hold_sub_addr;
                    r_mem_sub_data   <= r_hold_sub_data;
                end
                GNT_UPD: begin
                    r_mem_wr_vld     <= 1'b1;
                    r_mem_wr_address <= w_head.addr;
                    r_mem_wr_data    <= w_head.data;
                    r_mem_sub_vld    <= 1'b0;
                    r_mem_sub_addr   <= '0;
                    r_mem_sub_data   <= '0;
                end
                default: begin
                    r_mem_wr_vld     <= 1'b0;
                    r_mem_wr_address <= '0;
                    r_mem_wr_data    <= '0;
                    r_mem_sub_vld    <= 1'b0;
                    r_mem_sub_addr   <= '0;
                    r_mem_sub_data   <= '0;
                end
            endcase
        end
    end

    assign bus.err_rdy        = w_err_rdy;
    assign bus.upd_rdy        = w_upd_rdy;
    assign bus.mem_wr_vld     = r_mem_wr_vld;
    assign bus.mem_wr_address = r_mem_wr_address;
    assign bus.mem_wr_data    = r_mem_wr_data;
    assign bus.mem_sub_vld    = r_mem_sub_vld;
    assign bus.mem_sub_addr   = r_mem_sub_addr;
    assign bus.mem_sub_data   = r_mem_sub_data;
    assign bus.err_drop       = r_err_drop;
    assign bus.upd_level      = w_level;

endmodule

// File: doc/full_st0_tap_wr_arb.md
# full_st0_tap_wr_arb

Arbiter for the single stage-0 tap memory write port, shared by two requesters: error-accumulate sub-writes from the error path and full-word tap-update writes from the delayed read-back path. Sits between the stage-0 error/update logic and the `tap_int` write fields of the stage control block. Error writes have priority; tap updates are buffered in a small FIFO. An optional starvation guard bounds update latency.

## Interface
- DEPTH, 2, tap-update FIFO entries (power of two, ≥2)
- STARVE_MAX, 4, consecutive lost arbitrations before the update head is forced (fair mode only)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- err_vld  in  1  error sub-write request
- err_addr  in  5  tap word address (12..15 for error phases)
- err_sub_addr  in  32  sub-word select
- err_sub_data  in  32  sub-word value
- err_rdy  out  1  error hold register can accept
- upd_vld  in  1  tap-update write request
- upd_addr  in  5  tap word address
- upd_data  in  192  full tap word (6 × float_24_8)
- upd_rdy  out  1  FIFO not full
- mem_wr_vld  out  1  write strobe to tap memory
- mem_wr_address  out  5  write address
- mem_wr_data  out  192  write data (zero for error writes)
- mem_sub_vld  out  1  1 = sub-word write, 0 = full-word write
- mem_sub_addr  out  32  sub-word select (zero for update writes)
- mem_sub_data  out  32  sub-word value (zero for update writes)
- err_drop  out  1  sticky: error request arrived while err_rdy low
- upd_level  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Error hold: single register; loads on err_vld & err_rdy. err_rdy = ~hold_vld | err_grant (same-cycle refill allowed).
- Update FIFO: push on upd_vld & upd_rdy; pop on upd_grant. upd_rdy = level < DEPTH, combinational from registered level only (no same-cycle pop credit).
- Arbitration per cycle, at most one grant:
  - hold_vld & ~force → err_grant.
  - else FIFO non-empty → upd_grant.
  - force = starve_cnt == STARVE_MAX (fair mode only; 0 otherwise).
- Starvation counter (fair mode): increments when FIFO non-empty and err_grant; clears on upd_grant or FIFO empty; saturates at STARVE_MAX.
- Output register loads the granted entry; mem_wr_vld = 1 the cycle after any grant, otherwise 0, and all mem_* data fields are zeroed.
- err_drop sets on err_vld & ~err_rdy; cleared only by reset. The dropped request is discarded.
- Simultaneous push and pop: level unchanged. Full FIFO with concurrent pop: upd_rdy stays 0 that cycle.
- Pointer wrap: modulo DEPTH. Level counter is one bit wider than the pointers so that full and empty are distinct.

## Timing
- Reset values: mem_wr_vld, mem_sub_vld, err_drop, and all mem_* buses = 0; upd_level = 0; err_rdy = 1; upd_rdy = 1; starve_cnt = 0.
- Error latency: accepted at edge N, granted during cycle N+1, mem_wr_vld high during cycle N+2 (2 cycles) when uncontested.
- Update latency: pushed at edge N, head valid at N+1, written during N+2 when no error hold is pending.
- Throughput: one memory write per cycle. Sustained error writes every cycle give 1/cycle with no loss.
- Reset asserted mid-operation: FIFO contents, hold register and output are discarded immediately. No write is issued after reset deasserts until a new request arrives.

## Configuration
- FULL_ST0_TAP_ARB_FAIR_EN defined: the starvation guard is active. The update head wins after STARVE_MAX consecutive losses. The pending error stays in hold, err_rdy drops for that cycle, and err_drop can fire if a new error arrives.
- Not defined: strict error priority. starve_cnt and force are removed. Updates can starve indefinitely under continuous error traffic.

## Structure
- Shared package: float_24_8 typedef, tap word width (192), tap address width (5), error-phase base address constant (12).
- One sub-module: full_st0_tap_wr_fifo (parameterised DEPTH, width 197 = addr+data, push/pop/level).
- Arbiter, hold register, starvation counter and output register live in the top module.

## Test plan
- Reset idle: after reset, no requests → err_rdy=1, upd_rdy=1, mem_wr_vld=0, upd_level=0 for 20 cycles.
- Lone error: err_vld one cycle with addr=13, sub_addr=2, sub_data=0x3F800000 → mem_wr_vld 2 cycles later with mem_sub_vld=1, address 13, mem_wr_data=0.
- Collision: error (addr 12) and update (addr 3) presented the same cycle → error write at N+2, update write at N+3, upd_level back to 0.
- FIFO full: 3 back-to-back updates while errors hold the port → upd_rdy=0 after 2 pushes, third held. Once errors stop, writes drain in push order.
- Fairness (macro on, STARVE_MAX=4): continuous errors plus one update → update written after exactly 4 error grants, err_rdy low 1 cycle. Macro off → update never written while errors continue.
- Reset mid-drain: assert reset with FIFO level 2 → level=0, mem_wr_vld=0 immediately, no stale writes after release.
